snitch_icache_l0_refill_arb: RTL and testbench
==============================================

SNITCH_ICACHE_L0_REFILL_ARB -- requirements
Module: snitch_icache_l0_refill_arb

Interface
REQ-001 Parameter NR_PORTS, default 4: number of L0 caches sharing one L1 refill port.
REQ-002 Parameter FETCH_AW, default 32: refill address width.
REQ-003 Parameter LINE_WIDTH, default 128: refill line width.
REQ-004 Parameter ID_WIDTH, default 2*NR_PORTS: one-hot ID; bit 2*p = demand refill of port p, bit 2*p+1 = prefetch of port p.
REQ-005 Parameter MAX_PENDING, default 2: maximum outstanding refills per port; range 1..15.
REQ-006 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_ni  in  1  reset, synchronous, active-low.
REQ-008 in_req_addr_i  in  NR_PORTS x FETCH_AW  per-port refill address.
REQ-009 in_req_id_i  in  NR_PORTS x ID_WIDTH  per-port one-hot ID.
REQ-010 in_req_valid_i / in_req_ready_o  in/out  NR_PORTS each  per-port request handshake.
REQ-011 out_req_addr_o, out_req_id_o, out_req_valid_o  out  FETCH_AW, ID_WIDTH, 1  request to L1.
REQ-012 out_req_ready_i  in  1  L1 accepts request.
REQ-013 out_rsp_data_i, out_rsp_error_i, out_rsp_id_i, out_rsp_valid_i  in  LINE_WIDTH, 1, ID_WIDTH, 1  L1 response.
REQ-014 out_rsp_ready_o  out  1  response accepted.
REQ-015 in_rsp_data_o, in_rsp_error_o, in_rsp_id_o  out  broadcast copies of response fields, identical for all ports.
REQ-016 in_rsp_valid_o / in_rsp_ready_i  out/in  NR_PORTS each  per-port response handshake.
REQ-017 unmapped_rsp_o  out  1  pulse, response ID addressed no port.

Function
REQ-018 Eligible port p: in_req_valid_i[p] and pending[p] < MAX_PENDING.
REQ-019 Round-robin arbitration among eligible ports, search starts at rr_q; on grant of port g, rr_q <= (g+1) mod NR_PORTS; rr_q unchanged without grant.
REQ-020 One-entry output register; grant allowed when register empty or drained this cycle (out_req_valid_o & out_req_ready_i).
REQ-021 in_req_ready_o[g] high only for the granted port, combinationally, in the grant cycle; at most one bit set.
REQ-022 Latency: request accepted in cycle N appears on out_req_* in cycle N+1; fields held stable while out_req_valid_o & !out_req_ready_i.
REQ-023 Back-to-back: drain and new load in same cycle sustain one request per cycle.
REQ-024 pending[p] increments when port p is granted, decrements on response handshake addressed to p; both same cycle -> unchanged; never wraps.
REQ-025 Response target: port p addressed when out_rsp_id_i[2p] or [2p+1] set; in_rsp_valid_o[p] = out_rsp_valid_i & addressed(p).
REQ-026 out_rsp_ready_o = AND of in_rsp_ready_i over addressed ports; response consumed only when all addressed ports ready.
REQ-027 Response with no addressed port: out_rsp_ready_o = 1, unmapped_rsp_o = 1 that cycle, no counter change.
REQ-028 Requests with ID not in port p's two bits are a protocol error; assertion fires, behaviour undefined.
REQ-029 Assertions: in_req_ready_o onehot0; output request stable under backpressure; pending never exceeds MAX_PENDING.

Reset
REQ-030 On clk_i edge with rst_ni low: out_req_valid_o=0, rr_q=0, all pending=0; address/ID register not reset.
REQ-031 Reset mid-transaction drops held request and forgets outstanding refills; responses arriving afterward route normally without counter underflow (decrement at 0 ignored).
REQ-032 All outputs other than out_req_addr_o/out_req_id_o are known during reset.

Configuration
REQ-033 Macro SNITCH_ICACHE_ARB_PREFETCH_LOW_PRIO_EN defined: eligible demand requests (any even ID bit set) from any port win over all prefetches; round-robin applies within each class, one shared rr_q.
REQ-034 Macro undefined: pure round-robin, ID class ignored.

Verification
REQ-035 NR_PORTS=4, ports 0..3 valid continuously, L1 always ready -> grants 0,1,2,3,0 on consecutive cycles, one out_req per cycle.
REQ-036 Port 1 issues two requests, no responses, MAX_PENDING=2 -> third request stalls (ready=0) until response with ID 0b0000_0100 arrives; granted next cycle.
REQ-037 out_req_ready_i low 5 cycles with held addr 0x8000_0040 -> addr/ID stable, no new in_req_ready_o.
REQ-038 Response ID 0x00 -> out_rsp_ready_o=1, unmapped_rsp_o=1, all in_rsp_valid_o=0.
REQ-039 Macro defined, port 0 prefetch (ID 0x02) and port 2 demand (ID 0x10) valid with rr_q=0 -> port 2 granted first.
REQ-040 Reset asserted while out_req_valid_o=1 and pending[0]=1 -> next cycle out_req_valid_o=0, pending all 0, rr_q=0.

Source files
------------

// File: rtl/snitch_icache_l0_refill_arb.sv
// snitch_icache_l0_refill_arb: round-robin arbiter of L0 refill requests onto one L1 port, with response fan-out.
// Define SNITCH_ICACHE_ARB_PREFETCH_LOW_PRIO_EN to make demand refills win over prefetches.
module snitch_icache_l0_refill_arb #(
    parameter int unsigned NR_PORTS    = 4,
    parameter int unsigned FETCH_AW    = 32,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned ID_WIDTH    = 2 * NR_PORTS,
    parameter int unsigned MAX_PENDING = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NR_PORTS-1:0][FETCH_AW-1:0]  in_req_addr_i,
    input  logic [NR_PORTS-1:0][ID_WIDTH-1:0]  in_req_id_i,
    input  logic [NR_PORTS-1:0]                in_req_valid_i,
    output logic [NR_PORTS-1:0]                in_req_ready_o,
    output logic [FETCH_AW-1:0]                out_req_addr_o,
    output logic [ID_WIDTH-1:0]                out_req_id_o,
    output logic                               out_req_valid_o,
    input  logic                               out_req_ready_i,
    input  logic [LINE_WIDTH-1:0]              out_rsp_data_i,
    input  logic                               out_rsp_error_i,
    input  logic [ID_WIDTH-1:0]                out_rsp_id_i,
    input  logic                               out_rsp_valid_i,
    output logic                               out_rsp_ready_o,
    output logic [LINE_WIDTH-1:0]              in_rsp_data_o,
    output logic                               in_rsp_error_o,
    output logic [ID_WIDTH-1:0]                in_rsp_id_o,
    output logic [NR_PORTS-1:0]                in_rsp_valid_o,
    input  logic [NR_PORTS-1:0]                in_rsp_ready_i,
    output logic                               unmapped_rsp_o
);
    localparam int unsigned RW = NR_PORTS > 1 ? $clog2(NR_PORTS) : 1;
    localparam int unsigned PW = $clog2(MAX_PENDING + 1);

    logic [RW-1:0]                rr_q, gnt_idx, idx;
    logic [NR_PORTS-1:0][PW-1:0]  pending_q;
    logic [NR_PORTS-1:0]          elig, cand, addressed, inc, dec;
    logic                         gnt_valid, load, rsp_fire;
`ifdef SNITCH_ICACHE_ARB_PREFETCH_LOW_PRIO_EN
    logic [NR_PORTS-1:0]          demand;
`endif

    always_comb begin
        elig      = '0;
        addressed = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            elig[p]      = in_req_valid_i[p] && (pending_q[p] < PW'(MAX_PENDING));
            addressed[p] = |out_rsp_id_i[2*p +: 2];
        end
    end

`ifdef SNITCH_ICACHE_ARB_PREFETCH_LOW_PRIO_EN
    // Demand refills form their own class; prefetches only compete when no demand is eligible.
    always_comb begin
        demand = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            for (int unsigned b = 0; b < ID_WIDTH; b += 2) demand[p] = demand[p] | in_req_id_i[p][b];
        end
        cand = |(elig & demand) ? (elig & demand) : elig;
    end
`else
    assign cand = elig;
`endif

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            idx = RW'((rr_q + i) % NR_PORTS);
            if (cand[idx] && !gnt_valid) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    assign load     = gnt_valid && (!out_req_valid_o || out_req_ready_i);
    assign rsp_fire = out_rsp_valid_i && out_rsp_ready_o;

    always_comb begin
        in_req_ready_o = '0;
        inc            = '0;
        dec            = '0;
        if (load) in_req_ready_o[gnt_idx] = 1'b1;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            inc[p] = load && (gnt_idx == RW'(p));
            // Counters were cleared by reset for refills still in flight; ignore their late responses.
            dec[p] = rsp_fire && addressed[p] && (pending_q[p] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_req_valid_o <= 1'b0;
            rr_q            <= '0;
            pending_q       <= '0;
        end else begin
            if (load) begin
                out_req_valid_o <= 1'b1;
                rr_q            <= (gnt_idx == RW'(NR_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (out_req_ready_i) begin
                out_req_valid_o <= 1'b0;
            end
            for (int unsigned p = 0; p < NR_PORTS; p++)
                pending_q[p] <= pending_q[p] + PW'(inc[p]) - PW'(dec[p]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (load) begin
            out_req_addr_o <= in_req_addr_i[gnt_idx];
            out_req_id_o   <= in_req_id_i[gnt_idx];
        end
    end

    assign out_rsp_ready_o = &(in_rsp_ready_i | ~addressed);
    assign unmapped_rsp_o  = out_rsp_valid_i && !(|addressed);
    assign in_rsp_valid_o  = {NR_PORTS{out_rsp_valid_i}} & addressed;
    assign in_rsp_data_o   = out_rsp_data_i;
    assign in_rsp_error_o  = out_rsp_error_i;
    assign in_rsp_id_o     = out_rsp_id_i;

    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(in_req_ready_o));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_req_valid_o && !out_req_ready_i |=> out_req_valid_o && $stable(out_req_addr_o) && $stable(out_req_id_o));

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni) pending_q[p] <= PW'(MAX_PENDING));
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            in_req_valid_i[p] |-> (in_req_id_i[p] & ~(ID_WIDTH'(3) << (2 * p))) == '0);
    end
endmodule

// File: tb/tb_snitch_icache_l0_refill_arb.sv
// tb_snitch_icache_l0_refill_arb: directed and random stimulus against a transaction-level model of the refill arbiter.
module tb_snitch_icache_l0_refill_arb;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0][31:0]  in_req_addr = '0;
    logic [3:0][7:0]   in_req_id = '0;
    logic [3:0]        in_req_valid = '0;
    logic [3:0]        in_req_ready;
    logic [31:0]       out_req_addr;
    logic [7:0]        out_req_id;
    logic              out_req_valid;
    logic              out_req_ready = 1'b0;
    logic [127:0]      out_rsp_data = '0;
    logic              out_rsp_error = 1'b0;
    logic [7:0]        out_rsp_id = '0;
    logic              out_rsp_valid = 1'b0;
    logic              out_rsp_ready;
    logic [127:0]      in_rsp_data;
    logic              in_rsp_error;
    logic [7:0]        in_rsp_id;
    logic [3:0]        in_rsp_valid;
    logic [3:0]        in_rsp_ready = '0;
    logic              unmapped_rsp;

    snitch_icache_l0_refill_arb dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_req_addr_i(in_req_addr), .in_req_id_i(in_req_id),
        .in_req_valid_i(in_req_valid), .in_req_ready_o(in_req_ready),
        .out_req_addr_o(out_req_addr), .out_req_id_o(out_req_id),
        .out_req_valid_o(out_req_valid), .out_req_ready_i(out_req_ready),
        .out_rsp_data_i(out_rsp_data), .out_rsp_error_i(out_rsp_error),
        .out_rsp_id_i(out_rsp_id), .out_rsp_valid_i(out_rsp_valid),
        .out_rsp_ready_o(out_rsp_ready),
        .in_rsp_data_o(in_rsp_data), .in_rsp_error_o(in_rsp_error),
        .in_rsp_id_o(in_rsp_id), .in_rsp_valid_o(in_rsp_valid),
        .in_rsp_ready_i(in_rsp_ready), .unmapped_rsp_o(unmapped_rsp)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int pend [4];
    int rr = 0;
    bit mv = 0, synced = 0;
    logic [31:0] ma;
    logic [7:0]  mi;
    int gq[$];
    int exp_seq [5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit eligible(int p);
        return in_req_valid[p] && pend[p] < 2;
    endfunction

    // Round-robin from rr; with the low-priority-prefetch build, demand requests are searched first.
    function automatic int pick();
        int best = -1;
`ifdef SNITCH_ICACHE_ARB_PREFETCH_LOW_PRIO_EN
        for (int k = 0; k < 4 && best < 0; k++)
            if (eligible((rr + k) % 4) && (in_req_id[(rr + k) % 4] & 8'h55) != 0) best = (rr + k) % 4;
`endif
        for (int k = 0; k < 4 && best < 0; k++)
            if (eligible((rr + k) % 4)) best = (rr + k) % 4;
        return best;
    endfunction

    task automatic tick();
        int g;
        bit ld, orr, unm;
        logic [3:0] er, ev, ad;
        @(negedge clk);
        g   = pick();
        ld  = (g >= 0) && (!mv || out_req_ready);
        er  = ld ? 4'(1 << g) : 4'b0;
        orr = 1;
        for (int p = 0; p < 4; p++) begin
            ad[p] = out_rsp_id[2*p] | out_rsp_id[2*p+1];
            if (ad[p] && !in_rsp_ready[p]) orr = 0;
        end
        ev  = out_rsp_valid ? ad : 4'b0;
        unm = out_rsp_valid && ad == 0;
        if (synced) begin
            chk("in_req_ready", in_req_ready, er);
            chk("out_req_valid", out_req_valid, mv);
            if (mv) begin
                chk("out_req_addr", out_req_addr, ma);
                chk("out_req_id", out_req_id, mi);
            end
            chk("in_rsp_valid", in_rsp_valid, ev);
            chk("out_rsp_ready", out_rsp_ready, orr);
            chk("unmapped_rsp", unmapped_rsp, unm);
            chk("rsp_broadcast", {in_rsp_data ^ out_rsp_data, in_rsp_error ^ out_rsp_error, in_rsp_id ^ out_rsp_id} == '0, 1'b1);
        end
        @(posedge clk);
        if (!rst_n) begin
            mv = 0; rr = 0; synced = 1;
            for (int p = 0; p < 4; p++) pend[p] = 0;
        end else begin
            for (int p = 0; p < 4; p++)
                if (out_rsp_valid && orr && ad[p] && pend[p] > 0) pend[p]--;
            if (ld) begin
                pend[g]++; mv = 1; ma = in_req_addr[g]; mi = in_req_id[g]; rr = (g + 1) % 4;
            end else if (out_req_ready) mv = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_req_valid = '0; out_rsp_valid = 0; out_rsp_id = '0; out_req_ready = 0; in_rsp_ready = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) tick();
        rst_n = 1;
    endtask

    initial begin
        for (int p = 0; p < 4; p++) pend[p] = 0;
        do_reset();
        #1;
        chk("reset_out_valid", out_req_valid, 1'b0);
        chk("reset_in_ready", in_req_ready, 4'b0);

        // All four ports request continuously with L1 always ready.
        for (int p = 0; p < 4; p++) begin
            in_req_id[p] = 8'(1 << (2 * p));
            in_req_addr[p] = 32'h1000 + 32'(p) * 32'h100;
        end
        in_req_valid = 4'hf; out_req_ready = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            for (int p = 0; p < 4; p++) if (in_req_ready[p]) gq.push_back(p);
            tick();
        end
        chk("rr_count", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_seq", gq[i], exp_seq[i]);
        do_reset();

        // Port 1 reaches its outstanding limit and waits for a response.
        in_req_valid = 4'b0010; in_req_id[1] = 8'h04; in_req_addr[1] = 32'h2000;
        out_req_ready = 1; in_rsp_ready = 4'hf;
        #1 chk("pend_grant1", in_req_ready, 4'b0010);
        tick();
        #1 chk("pend_grant2", in_req_ready, 4'b0010);
        tick();
        repeat (3) begin
            #1 chk("pend_stall", in_req_ready, 4'b0000);
            tick();
        end
        out_rsp_valid = 1; out_rsp_id = 8'h04;
        #1 chk("pend_stall_rsp", in_req_ready, 4'b0000);
        chk("pend_rsp_ready", out_rsp_ready, 1'b1);
        chk("pend_rsp_valid", in_rsp_valid, 4'b0010);
        tick();
        out_rsp_valid = 0; out_rsp_id = '0;
        #1 chk("pend_regrant", in_req_ready, 4'b0010);
        tick();
        do_reset();

        // Backpressure holds the request register.
        in_req_valid = 4'b0001; in_req_addr[0] = 32'h8000_0040; in_req_id[0] = 8'h01; out_req_ready = 0;
        tick();
        in_req_valid = 4'hf; in_req_addr[0] = 32'h1234_5678;
        repeat (5) begin
            #1 chk("bp_addr", out_req_addr, 32'h8000_0040);
            chk("bp_id", out_req_id, 8'h01);
            chk("bp_valid", out_req_valid, 1'b1);
            chk("bp_ready", in_req_ready, 4'b0);
            tick();
        end
        out_req_ready = 1; in_req_valid = '0;
        repeat (2) tick();

        // Response with no addressed port.
        out_rsp_valid = 1; out_rsp_id = 8'h00; in_rsp_ready = '0;
        #1 chk("unm_ready", out_rsp_ready, 1'b1);
        chk("unm_pulse", unmapped_rsp, 1'b1);
        chk("unm_valid", in_rsp_valid, 4'b0);
        tick();
        out_rsp_valid = 0;

        // Reset while a request is held and port 0 has one refill outstanding.
        do_reset();
        in_req_valid = 4'b0001; in_req_id[0] = 8'h01; in_req_addr[0] = 32'h3000; out_req_ready = 0;
        tick();
        #1 chk("rst_mid_valid_before", out_req_valid, 1'b1);
        rst_n = 0; in_req_valid = '0;
        tick();
        rst_n = 1;
        #1 chk("rst_mid_valid_after", out_req_valid, 1'b0);
        for (int p = 0; p < 4; p++) in_req_id[p] = 8'(1 << (2 * p));
        in_req_valid = 4'hf; out_req_ready = 1;
        #1 chk("rst_mid_rr0", in_req_ready, 4'b0001);
        tick();
        in_req_valid = 4'b0001;
        #1 chk("rst_mid_pend_clear", in_req_ready, 4'b0001);
        tick();
        #1 chk("rst_mid_pend_full", in_req_ready, 4'b0000);
        in_req_valid = '0;
        tick();

        // Port 0 prefetch against port 2 demand with rr at 0.
        do_reset();
        in_req_valid = 4'b0101; in_req_id[0] = 8'h02; in_req_id[2] = 8'h10; out_req_ready = 1;
`ifdef SNITCH_ICACHE_ARB_PREFETCH_LOW_PRIO_EN
        #1 chk("prio_demand_first", in_req_ready, 4'b0100);
`else
        #1 chk("prio_pure_rr", in_req_ready, 4'b0001);
`endif
        tick();
        in_req_valid = '0;
        tick();

        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom % 150) != 0;
            in_req_valid = 4'($urandom);
            for (int p = 0; p < 4; p++) begin
                in_req_id[p] = 8'(1 << (2 * p + int'($urandom % 2)));
                in_req_addr[p] = $urandom;
            end
            out_req_ready = ($urandom % 4) != 0;
            out_rsp_valid = ($urandom % 3) == 0;
            out_rsp_id = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
            out_rsp_data = {$urandom, $urandom, $urandom, $urandom};
            out_rsp_error = 1'($urandom);
            in_rsp_ready = ($urandom % 2) ? 4'hf : 4'($urandom);
            tick();
        end
        rst_n = 1;
        idle_inputs();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
